sparse_chunk_pingpong: RTL
==========================

# sparse_chunk_pingpong

Double-buffered, parametrised sparse-chunk store: the next generation of the single-bank chunk memory. It holds two chunks, each a sparsemap (1 bit per dense element) plus its compacted nonzero bytes. A producer fills one bank through a valid/ready stream with an internal beat counter while the PE array reads the other bank. Reads return registered sparsemap slices and nonzero data. It sits between the DMA/unpacker and the prefix-sum/PE read path.

## Interface
- MEM_SIZE, 512: dense elements per chunk (sparsemap bits and nonzero entries per bank).
- BUS_SIZE, 128: sparsemap bits and nonzero entries written per beat; MEM_SIZE % BUS_SIZE == 0.
- PREFIX_SUM_SIZE, 32: sparsemap slice width per read; MEM_SIZE % PREFIX_SUM_SIZE == 0.
- DATA_W, 8: nonzero element width.
- Derived: WR_CYC = MEM_SIZE/BUS_SIZE (≥1); SM_NUM = MEM_SIZE/PREFIX_SUM_SIZE.

Ports:
- clk_i  in  1  clock. Single clock domain.
- rst_i  in  1  reset, asynchronous, active-high.
- wr_valid_i  in  1  write beat valid.
- wr_ready_o  out  1  write bank can accept a beat.
- wr_sparsemap_i  in  BUS_SIZE  sparsemap bits for this beat.
- wr_nonzero_data_i  in  BUS_SIZE×DATA_W  nonzero entries for this beat.
- wr_bank_o  out  1  bank currently being filled.
- rd_bank_valid_o  out  1  read bank holds a complete chunk.
- rd_bank_o  out  1  bank currently exposed for reading.
- rd_release_i  in  1  consumer is done with the read bank.
- rd_addr_i  in  clog2(MEM_SIZE)+1  nonzero index, 1-based; 0 means "no element".
- rd_data_o  out  DATA_W  registered nonzero data.
- rd_sparsemap_addr_i  in  clog2(SM_NUM)  sparsemap slice index.
- rd_sparsemap_o  out  PREFIX_SUM_SIZE  registered sparsemap slice.

## Operation
- Storage: per bank, sparsemap[MEM_SIZE] and nonzero[1..MEM_SIZE]. Arrays are not reset. Only control state and outputs are reset.
- Control state: wr_bank_r, rd_bank_r, full_r[1:0], wr_cnt_r (clog2(WR_CYC) bits, or 1 bit when WR_CYC=1).
- wr_ready_o = !full_r[wr_bank_r]. It is driven from registers only, with no combinational path from any input.
- Beat accepted when wr_valid_i && wr_ready_o:
  - Sparsemap bits [BUS_SIZE*wr_cnt_r +: BUS_SIZE] of bank wr_bank_r are written.
  - Nonzero entries [BUS_SIZE*wr_cnt_r+1 +: BUS_SIZE] of that bank are written.
  - wr_cnt_r increments.
- Last beat (wr_cnt_r == WR_CYC-1) accepted: full_r[wr_bank_r] is set, wr_cnt_r wraps to 0, wr_bank_r toggles.
- rd_bank_valid_o = full_r[rd_bank_r].
- rd_release_i with rd_bank_valid_o=1 clears full_r[rd_bank_r] and toggles rd_bank_r. rd_release_i with rd_bank_valid_o=0 is ignored.
- A last-beat commit and a release in the same cycle always target different banks. Both take effect.
- Read data path, sampled every cycle from bank rd_bank_r:
  - rd_data_o <= (rd_bank_valid_o && 1 ≤ rd_addr_i ≤ MEM_SIZE) ? nonzero[rd_addr_i] : 0.
  - rd_sparsemap_o <= rd_bank_valid_o ? sparsemap[PREFIX_SUM_SIZE*rd_sparsemap_addr_i +: PREFIX_SUM_SIZE] : 0.
- A read issued in the release cycle still returns the releasing bank's data.
- Data is not cleared on release. The next fill overwrites it.

## Timing
- Reset values: wr_bank_r=0, rd_bank_r=0, full_r=0, wr_cnt_r=0. Outputs: wr_ready_o=1, wr_bank_o=0, rd_bank_valid_o=0, rd_bank_o=0, rd_data_o=0, rd_sparsemap_o=0.
- Fill takes exactly WR_CYC accepted beats. Gaps (valid low) are allowed and hold wr_cnt_r.
- rd_bank_valid_o rises the cycle after the last beat is accepted, when that bank is the read bank.
- Read latency is 1 cycle, addresses to registered outputs. Full throughput: one data read and one sparsemap read per cycle.
- Release takes effect at the clock edge:
  - rd_bank_valid_o reflects the other bank's full flag next cycle.
  - wr_ready_o rises next cycle when the writer was stalled on the released bank.
- Both banks full: wr_ready_o=0. The producer holds the beat; no beat is dropped or overwritten.
- Reset mid-fill discards the partial chunk and the full flags. Filling restarts at bank 0, beat 0.

## Test plan
- Single chunk, defaults: 4 beats with beat k sparsemap = {32{4'hk}} and nonzero[j] = j[7:0]. Expected response:
  - rd_bank_valid_o=1 one cycle after beat 3.
  - rd_addr_i=5 → rd_data_o=8'h05 next cycle.
  - rd_sparsemap_addr_i=4 → 32'h11111111.
- Ping-pong with backpressure: fill bank 0, fill bank 1, then present a 9th beat. Expected response:
  - wr_ready_o=0; the 9th beat is held.
  - rd_release_i pulse → wr_ready_o=1 next cycle; rd_bank_o=1; bank 1 data is readable.
  - The held beat lands in bank 0 at beat 0.
- Simultaneous events: bank 0 full and read, bank 1 on beat 3. Release and last beat in the same cycle → next cycle rd_bank_o=1, rd_bank_valid_o=1, wr_bank_o=0, wr_ready_o=1.
- Address edges: rd_addr_i=0 → 0; rd_addr_i=512 → nonzero[512]; rd_addr_i=513 → 0. Any read with rd_bank_valid_o=0 → 0. rd_release_i with no valid bank → no state change.
- Reset mid-fill: assert rst_i asynchronously after 2 beats. Expected: outputs go to reset values immediately, without waiting for a clock edge. After deassertion, 4 fresh beats → bank 0 valid with only the new data.
- Parameter sweep: MEM_SIZE=256, BUS_SIZE=256 (WR_CYC=1), PREFIX_SUM_SIZE=64, DATA_W=16. Expected: a single beat commits the bank; 16-bit data reads back correctly.

Source files
------------

// File: rtl/sparse_chunk_pingpong.sv
// Double-buffered sparse-chunk store: a producer fills one bank (sparsemap + compacted
// nonzeros) beat by beat while the reader samples the other bank through registered outputs.
module sparse_chunk_pingpong #(
    parameter int MEM_SIZE        = 512,
    parameter int BUS_SIZE        = 128,
    parameter int PREFIX_SUM_SIZE = 32,
    parameter int DATA_W          = 8,
    localparam int WR_CYC = MEM_SIZE / BUS_SIZE,
    localparam int SM_NUM = MEM_SIZE / PREFIX_SUM_SIZE,
    localparam int MW     = $clog2(MEM_SIZE),
    localparam int AW     = MW + 1,
    localparam int SMW    = (SM_NUM > 1) ? $clog2(SM_NUM) : 1,
    localparam int CW     = (WR_CYC > 1) ? $clog2(WR_CYC) : 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         wr_valid_i,
    output logic                         wr_ready_o,
    input  logic [BUS_SIZE-1:0]          wr_sparsemap_i,
    input  logic [BUS_SIZE*DATA_W-1:0]   wr_nonzero_data_i,
    output logic                         wr_bank_o,
    output logic                         rd_bank_valid_o,
    output logic                         rd_bank_o,
    input  logic                         rd_release_i,
    input  logic [AW-1:0]                rd_addr_i,
    output logic [DATA_W-1:0]            rd_data_o,
    input  logic [SMW-1:0]               rd_sparsemap_addr_i,
    output logic [PREFIX_SUM_SIZE-1:0]   rd_sparsemap_o
);

    logic                       wr_bank_q, wr_bank_d;
    logic                       rd_bank_q, rd_bank_d;
    logic [1:0]                 full_q, full_d;
    logic [CW-1:0]              wr_cnt_q, wr_cnt_d;
    logic [DATA_W-1:0]          rd_data_q, rd_data_d;
    logic [PREFIX_SUM_SIZE-1:0] rd_sm_q, rd_sm_d;

    logic [MEM_SIZE-1:0]        sm_mem_q [2];
    logic [DATA_W-1:0]          nz_mem_q [2][MEM_SIZE];

    logic                       wr_fire_s, wr_last_s, rel_fire_s, rd_addr_ok_s;
    logic [MW-1:0]              wr_base_s, sm_base_s, rd_idx_s;

    assign wr_ready_o      = ~full_q[wr_bank_q];
    assign rd_bank_valid_o = full_q[rd_bank_q];
    assign wr_bank_o       = wr_bank_q;
    assign rd_bank_o       = rd_bank_q;
    assign rd_data_o       = rd_data_q;
    assign rd_sparsemap_o  = rd_sm_q;

    // Next-state for bank pointers, full flags and beat counter.
    always_comb begin
        wr_fire_s  = wr_valid_i & wr_ready_o;
        wr_last_s  = (wr_cnt_q == CW'(WR_CYC - 1));
        rel_fire_s = rd_release_i & rd_bank_valid_o;
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        full_d     = full_q;
        wr_cnt_d   = wr_cnt_q;
        if (wr_fire_s) begin
            if (wr_last_s) begin
                full_d[wr_bank_q] = 1'b1;
                wr_cnt_d          = {CW{1'b0}};
                wr_bank_d         = ~wr_bank_q;
            end else begin
                wr_cnt_d = wr_cnt_q + CW'(1);
            end
        end else begin
            wr_cnt_d = wr_cnt_q;
        end
        // Commit and release never hit the same bank, so both updates can stack.
        if (rel_fire_s) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
        end else begin
            rd_bank_d = rd_bank_q;
        end
    end

    // Read-side address decode and next values of the registered read outputs.
    always_comb begin
        wr_base_s    = MW'(BUS_SIZE) * MW'(wr_cnt_q);
        sm_base_s    = MW'(PREFIX_SUM_SIZE) * MW'(rd_sparsemap_addr_i);
        rd_idx_s     = MW'(rd_addr_i - AW'(1));
        rd_addr_ok_s = (rd_addr_i != {AW{1'b0}}) && (rd_addr_i <= AW'(MEM_SIZE));
        if (rd_bank_valid_o && rd_addr_ok_s) begin
            rd_data_d = nz_mem_q[rd_bank_q][rd_idx_s];
        end else begin
            rd_data_d = {DATA_W{1'b0}};
        end
        if (rd_bank_valid_o) begin
            rd_sm_d = sm_mem_q[rd_bank_q][sm_base_s +: PREFIX_SUM_SIZE];
        end else begin
            rd_sm_d = {PREFIX_SUM_SIZE{1'b0}};
        end
    end

    // Control state and read output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            full_q    <= 2'b00;
            wr_cnt_q  <= {CW{1'b0}};
            rd_data_q <= {DATA_W{1'b0}};
            rd_sm_q   <= {PREFIX_SUM_SIZE{1'b0}};
        end else begin
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            full_q    <= full_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_data_q <= rd_data_d;
            rd_sm_q   <= rd_sm_d;
        end
    end

    // Bank storage; nonzero index j (1-based) lives at slot j-1.
    always_ff @(posedge clk_i) begin
        if (wr_fire_s) begin
            sm_mem_q[wr_bank_q][wr_base_s +: BUS_SIZE] <= wr_sparsemap_i;
            for (int i = 0; i < BUS_SIZE; i++) begin
                nz_mem_q[wr_bank_q][wr_base_s + MW'(i)] <= wr_nonzero_data_i[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule
